// File: rtl/otbn_pkg.sv
// Shared OTBN widths and the EDN arbiter state encoding.
package otbn_pkg;

    localparam int unsigned WLEN            = 256;
    localparam int unsigned EdnDataWidth    = 32;
    localparam int unsigned EdnWordsPerWlen = WLEN / EdnDataWidth;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } otbn_edn_arb_state_e;

endpackage

// File: rtl/otbn_edn_packer.sv
// Packs successive EDN transfers into one WLEN word and accumulates the FIPS/error flags.
module otbn_edn_packer
    import otbn_pkg::*;
#(
    parameter int unsigned EdnWords = EdnWordsPerWlen
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               clear_i,
    input  logic                               ack_i,
    input  logic [EdnDataWidth-1:0]            data_i,
    input  logic                               fips_i,
    input  logic                               err_i,
    output logic                               word_done_o,
    output logic [EdnWords*EdnDataWidth-1:0]   word_o,
    output logic                               fips_o,
    output logic                               err_o
);

    localparam int unsigned W    = EdnWords * EdnDataWidth;
    localparam int unsigned CntW = (EdnWords > 1) ? $clog2(EdnWords) : 1;

    logic [CntW-1:0] cnt_q;
    logic [W-1:0]    pack_q;
    logic [W-1:0]    pack_d;
    logic            fips_q;
    logic            err_q;

    // Current transfer lands in slot cnt, slot 0 at the LSBs.
    always_comb begin
        pack_d = pack_q;
        for (int unsigned i = 0; i < EdnWords; i++) begin
            if (cnt_q == CntW'(i)) begin
                pack_d[i*EdnDataWidth +: EdnDataWidth] = data_i;
            end
        end
    end

    assign word_done_o = ack_i & (cnt_q == CntW'(EdnWords - 1));
    assign word_o      = pack_d;
    assign fips_o      = fips_q & fips_i;
    assign err_o       = err_q | err_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i || word_done_o) begin
            cnt_q  <= '0;
            pack_q <= '0;
            fips_q <= 1'b1;
            err_q  <= 1'b0;
        end else if (ack_i) begin
            cnt_q  <= cnt_q + CntW'(1);
            pack_q <= pack_d;
            fips_q <= fips_o;
            err_q  <= err_o;
        end
    end

endmodule

// File: rtl/otbn_edn_arb.sv
// Arbitrates the RND and URND clients onto one EDN port, fetching EdnWords transfers per grant.
module otbn_edn_arb
    import otbn_pkg::*;
#(
    parameter int unsigned EdnWords = EdnWordsPerWlen
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               wipe_i,
    input  logic                               rnd_req_i,
    input  logic                               urnd_req_i,
    output logic                               rnd_ack_o,
    output logic                               urnd_ack_o,
    output logic [EdnWords*EdnDataWidth-1:0]   rnd_data_o,
    output logic [EdnWords*EdnDataWidth-1:0]   urnd_data_o,
    output logic                               rnd_fips_o,
    output logic                               rnd_err_o,
    output logic                               edn_req_o,
    input  logic                               edn_ack_i,
    input  logic [EdnDataWidth-1:0]            edn_data_i,
    input  logic                               edn_fips_i,
    input  logic                               edn_err_i,
    output logic                               busy_o
);

    localparam int unsigned W = EdnWords * EdnDataWidth;

    otbn_edn_arb_state_e state_q;
    logic         edn_req_q, busy_q, gnt_urnd_q, prio_urnd_q;
    logic         rnd_ack_q, urnd_ack_q, rnd_fips_q, rnd_err_q;
    logic [W-1:0] rnd_data_q, urnd_data_q;

    logic         pick_urnd, fetch_wipe, pack_ack, word_done, pack_fips, pack_err;
    logic [W-1:0] pack_word;

    // prio_urnd_q set means URND wins a tie; it points away from the last grant.
    assign pick_urnd  = urnd_req_i & (~rnd_req_i | prio_urnd_q);
    assign fetch_wipe = (state_q == FETCH) & wipe_i;
    assign pack_ack   = (state_q == FETCH) & edn_ack_i & ~wipe_i;

    otbn_edn_packer #(
        .EdnWords (EdnWords)
    ) u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (fetch_wipe),
        .ack_i       (pack_ack),
        .data_i      (edn_data_i),
        .fips_i      (edn_fips_i),
        .err_i       (edn_err_i),
        .word_done_o (word_done),
        .word_o      (pack_word),
        .fips_o      (pack_fips),
        .err_o       (pack_err)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            edn_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            gnt_urnd_q  <= 1'b0;
            prio_urnd_q <= 1'b0;
            rnd_ack_q   <= 1'b0;
            urnd_ack_q  <= 1'b0;
            rnd_data_q  <= '0;
            urnd_data_q <= '0;
            rnd_fips_q  <= 1'b0;
            rnd_err_q   <= 1'b0;
        end else begin
            rnd_ack_q   <= 1'b0;
            urnd_ack_q  <= 1'b0;
            rnd_data_q  <= '0;
            urnd_data_q <= '0;
            rnd_fips_q  <= 1'b0;
            rnd_err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!wipe_i && (rnd_req_i || urnd_req_i)) begin
                        state_q     <= FETCH;
                        edn_req_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        gnt_urnd_q  <= pick_urnd;
                        prio_urnd_q <= ~pick_urnd;
                    end
                end
                FETCH: begin
                    // An outstanding EDN request cannot be withdrawn, so a wipe without ack drains it.
                    if (wipe_i) begin
                        if (edn_ack_i) begin
                            state_q   <= IDLE;
                            edn_req_q <= 1'b0;
                            busy_q    <= 1'b0;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else if (word_done) begin
                        state_q   <= IDLE;
                        edn_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        if (gnt_urnd_q) begin
                            urnd_ack_q  <= 1'b1;
                            urnd_data_q <= pack_word;
                        end else begin
                            rnd_ack_q  <= 1'b1;
                            rnd_data_q <= pack_word;
                            rnd_fips_q <= pack_fips;
                            rnd_err_q  <= pack_err;
                        end
                    end
                end
                DRAIN: begin
                    if (edn_ack_i) begin
                        state_q   <= IDLE;
                        edn_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    edn_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign rnd_ack_o   = rnd_ack_q;
    assign urnd_ack_o  = urnd_ack_q;
    assign rnd_data_o  = rnd_data_q;
    assign urnd_data_o = urnd_data_q;
    assign rnd_fips_o  = rnd_fips_q;
    assign rnd_err_o   = rnd_err_q;
    assign edn_req_o   = edn_req_q;
    assign busy_o      = busy_q;

    a_one_ack: assert property (@(posedge clk_i) disable iff (rst_i)
        !(rnd_ack_q && urnd_ack_q));

    a_req_hold: assert property (@(posedge clk_i)
        (!rst_i && !$past(rst_i) && $fell(edn_req_q)) |-> $past(edn_ack_i));

    a_rnd_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == FETCH && !wipe_i && !gnt_urnd_q) |-> rnd_req_i);

    a_urnd_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == FETCH && !wipe_i && gnt_urnd_q) |-> urnd_req_i);

endmodule
